// File: rtl/mem_port_arbiter.sv
`timescale 1ns / 1ps
// mem_port_arbiter: shares one memory port between instruction fetch (I) and
// data access (D). One transaction in flight at a time. D has priority, and a
// starvation counter forces an I grant after STARVE_LIMIT D wins over a waiting I.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic [3:0]  d_req_we,
    input  logic [31:0] d_req_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic        owner_d
);

    // A zero limit still needs a 1-bit counter to keep the vector legal.
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            owner_is_d_q, owner_is_d_d;

    logic idle, d_win, i_win, d_accept, i_accept, complete;

    // Grant decision and completion detect.
    always_comb begin
        idle     = (state_q == StIdle);
        d_win    = d_req_valid && (!i_req_valid || (starve_cnt_q < CntMax));
        i_win    = i_req_valid && !d_win;
        d_accept = idle && d_win;
        i_accept = idle && i_win;
        complete = ((state_q == StIssue) && mem_req_ready && mem_resp_valid) ||
                   ((state_q == StWait) && mem_resp_valid);
    end

    // Next-state, request latching and starvation counter update.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        owner_is_d_d = owner_is_d_q;
        unique case (state_q)
            StIdle: begin
                if (d_accept) begin
                    state_d      = StIssue;
                    addr_d       = d_req_addr;
                    we_d         = d_req_we;
                    wdata_d      = d_req_wdata;
                    owner_is_d_d = 1'b1;
                    if (i_req_valid && (starve_cnt_q != CntMax)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_accept) begin
                    state_d      = StIssue;
                    addr_d       = i_req_addr;
                    we_d         = 4'b0000;
                    wdata_d      = 32'h0;
                    owner_is_d_d = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            StIssue: begin
                // A same-cycle ack completes without visiting StWait.
                if (mem_req_ready) begin
                    state_d = mem_resp_valid ? StIdle : StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            addr_q       <= 32'h0;
            we_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            owner_is_d_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            owner_is_d_q <= owner_is_d_d;
        end
    end

    // Outputs; readys are gated by reset so nothing looks accepted while held in reset.
    always_comb begin
        d_req_ready   = reset_n && d_accept;
        i_req_ready   = reset_n && i_accept;
        mem_req_valid = (state_q == StIssue);
        mem_req_addr  = addr_q;
        mem_req_we    = we_q;
        mem_req_wdata = wdata_q;
        i_resp_valid  = complete && !owner_is_d_q;
        d_resp_valid  = complete && owner_is_d_q;
        i_resp_data   = i_resp_valid ? mem_resp_data : 32'h0;
        d_resp_data   = d_resp_valid ? mem_resp_data : 32'h0;
        busy          = !idle;
        owner_d       = busy && owner_is_d_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns / 1ps
// Bench for mem_port_arbiter: table of single transactions, then hand-written
// back-pressure, starvation and reset-mid-transaction sequences.
module tb_mem_port_arbiter;

    localparam int unsigned StarveLimit = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_we;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_we;
    logic        busy, owner_d;

    mem_port_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_req_we      (d_req_we),
        .d_req_wdata   (d_req_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .busy          (busy),
        .owner_d       (owner_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        own_d;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [3:0]  dwe;
        logic [31:0] dwd;
        int          lat;
        logic [31:0] rdata;
        logic        exp_d;
    } vec_t;

    mem_exp_t sb_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       model_cnt = 0;

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Present requests in an IDLE cycle, check the grant, push the expected memory request.
    task automatic offer(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd,
                         output logic got_d);
        logic exp_d, exp_i;
        mem_exp_t e;
        i_req_valid = iv;
        i_req_addr  = ia;
        d_req_valid = dv;
        d_req_addr  = da;
        d_req_we    = dwe;
        d_req_wdata = dwd;
        exp_d = dv && (!iv || (model_cnt < int'(StarveLimit)));
        exp_i = iv && !exp_d;
        mid();
        check_b("busy_idle", busy, 1'b0);
        check_b("mem_req_valid_idle", mem_req_valid, 1'b0);
        check_b("i_resp_valid_idle", i_resp_valid, 1'b0);
        check_b("d_resp_valid_idle", d_resp_valid, 1'b0);
        check_b("d_req_ready", d_req_ready, exp_d);
        check_b("i_req_ready", i_req_ready, exp_i);
        got_d = d_req_ready;
        if (exp_d) begin
            e = '{own_d: 1'b1, addr: da, we: dwe, wdata: dwd};
            sb_q.push_back(e);
            if (iv && (model_cnt < int'(StarveLimit))) model_cnt++;
        end else if (exp_i) begin
            e = '{own_d: 1'b0, addr: ia, we: 4'b0000, wdata: 32'h0};
            sb_q.push_back(e);
            model_cnt = 0;
        end
        step();
        if (exp_d) d_req_valid = 1'b0;
        if (exp_i) i_req_valid = 1'b0;
    endtask

    // Called in the ISSUE cycle: accept it, respond lat cycles later, end in the next IDLE.
    task automatic serve(input int lat, input logic [31:0] rdata);
        mem_exp_t e;
        mem_req_ready  = 1'b1;
        mem_resp_valid = (lat == 0);
        mem_resp_data  = rdata;
        mid();
        check_b("mem_req_valid", mem_req_valid, 1'b1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: memory request with no expected entry");
            e = '{own_d: 1'b0, addr: 32'h0, we: 4'b0000, wdata: 32'h0};
        end else begin
            e = sb_q.pop_front();
        end
        check_w("mem_req_addr", mem_req_addr, e.addr);
        check_w("mem_req_we", 32'(mem_req_we), 32'(e.we));
        check_w("mem_req_wdata", mem_req_wdata, e.wdata);
        check_b("owner_d", owner_d, e.own_d);
        check_b("i_req_ready_busy", i_req_ready, 1'b0);
        check_b("d_req_ready_busy", d_req_ready, 1'b0);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                step();
                mem_req_ready  = 1'b0;
                mem_resp_valid = (k == lat);
                mid();
                check_b("busy_wait", busy, 1'b1);
                check_b("mem_req_valid_wait", mem_req_valid, 1'b0);
            end
            check_b("i_resp_valid", i_resp_valid, (k == lat) && !e.own_d);
            check_b("d_resp_valid", d_resp_valid, (k == lat) && e.own_d);
            if (k == lat) check_w("resp_data", e.own_d ? d_resp_data : i_resp_data, rdata);
        end
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    vec_t vecs[4];
    logic got;
    logic exp_seq[10];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0, 4'b0000, 32'h0, 2, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_1004, 1'b1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,
                    1'b1};
        vecs[2] = '{1'b1, 32'h0000_1004, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0010_0093, 1'b0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h0000_2002, 4'b0011, 32'h0000_BEEF, 3, 32'h1234_5678,
                    1'b1};
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with requests active: every output must be zero.
        reset_n        = 1'b0;
        i_req_valid    = 1'b1;
        i_req_addr     = 32'h0000_0AAA;
        d_req_valid    = 1'b1;
        d_req_addr     = 32'h0000_0BBB;
        d_req_we       = 4'b1111;
        d_req_wdata    = 32'hFFFF_FFFF;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFFFF_FFFF;
        repeat (3) step();
        mid();
        check_b("rst_i_req_ready", i_req_ready, 1'b0);
        check_b("rst_d_req_ready", d_req_ready, 1'b0);
        check_b("rst_i_resp_valid", i_resp_valid, 1'b0);
        check_b("rst_d_resp_valid", d_resp_valid, 1'b0);
        check_w("rst_i_resp_data", i_resp_data, 32'h0);
        check_w("rst_d_resp_data", d_resp_data, 32'h0);
        check_b("rst_mem_req_valid", mem_req_valid, 1'b0);
        check_w("rst_mem_req_addr", mem_req_addr, 32'h0);
        check_w("rst_mem_req_we", 32'(mem_req_we), 32'h0);
        check_w("rst_mem_req_wdata", mem_req_wdata, 32'h0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_owner_d", owner_d, 1'b0);
        step();
        reset_n        = 1'b1;
        i_req_valid    = 1'b0;
        d_req_valid    = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mid();
        check_b("rel_busy", busy, 1'b0);
        check_b("rel_i_req_ready", i_req_ready, 1'b0);
        check_b("rel_d_req_ready", d_req_ready, 1'b0);
        step();

        // Table: single fetch, tie (D first), loser I served next, D halfword store.
        for (int v = 0; v < 4; v++) begin
            offer(vecs[v].iv, vecs[v].ia, vecs[v].dv, vecs[v].da, vecs[v].dwe, vecs[v].dwd, got);
            check_b("vec_winner", got, vecs[v].exp_d);
            serve(vecs[v].lat, vecs[v].rdata);
        end

        // Back-pressure on a byte store: request held stable, no readys.
        offer(1'b0, 32'h0, 1'b1, 32'h0000_3001, 4'b0001, 32'h0000_00AB, got);
        for (int c = 0; c < 3; c++) begin
            mem_req_ready = 1'b0;
            i_req_valid   = 1'b1;
            d_req_valid   = 1'b1;
            mid();
            check_b("bp_mem_req_valid", mem_req_valid, 1'b1);
            check_w("bp_mem_req_addr", mem_req_addr, 32'h0000_3001);
            check_w("bp_mem_req_we", 32'(mem_req_we), 32'h1);
            check_w("bp_mem_req_wdata", mem_req_wdata, 32'h0000_00AB);
            check_b("bp_i_req_ready", i_req_ready, 1'b0);
            check_b("bp_d_req_ready", d_req_ready, 1'b0);
            step();
        end
        serve(1, 32'h0);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        step();

        // Starvation: both always valid, same-cycle ack.
        for (int n = 0; n < 10; n++) begin
            offer(1'b1, 32'h0000_0100 + 32'(n * 4), 1'b1, 32'h0000_4000 + 32'(n * 4), 4'b1111,
                  32'hA000_0000 + 32'(n), got);
            check_b("starve_seq", got, exp_seq[n]);
            serve(0, 32'h5000_0000 + 32'(n));
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        step();

        // Reset during WAIT, then a stray response after release.
        offer(1'b1, 32'h0000_5000, 1'b0, 32'h0, 4'b0000, 32'h0, got);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mid();
        check_b("wait_busy", busy, 1'b1);
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        reset_n     = 1'b0;
        #1;
        check_b("midrst_busy", busy, 1'b0);
        check_b("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check_w("midrst_mem_req_addr", mem_req_addr, 32'h0);
        check_b("midrst_i_req_ready", i_req_ready, 1'b0);
        check_b("midrst_d_req_ready", d_req_ready, 1'b0);
        sb_q.delete();
        model_cnt = 0;
        step();
        reset_n        = 1'b1;
        i_req_valid    = 1'b0;
        d_req_valid    = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_1234;
        mid();
        check_b("late_i_resp_valid", i_resp_valid, 1'b0);
        check_b("late_d_resp_valid", d_resp_valid, 1'b0);
        check_b("late_busy", busy, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        offer(1'b0, 32'h0, 1'b1, 32'h0000_6000, 4'b0000, 32'h0, got);
        check_b("post_rst_grant", got, 1'b1);
        serve(1, 32'hCAFE_F00D);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single-ported backing memory between the pipeline's instruction fetch (I) and data access (D) paths. It accepts one request at a time from either side, issues it to memory, waits for the acknowledgement and routes the response back to the owner. It sits between the fetch stage / load-store path and the memory interface. D has priority, and a starvation counter guarantees forward progress for I.

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while I is waiting before I is forced to win; 0 = I wins every tie
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  fetch request present
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  32  fetch address
- i_resp_valid  out  1  one-cycle pulse, fetch data valid
- i_resp_data  out  32  fetch data
- d_req_valid  in  1  data request present
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  32  data address
- d_req_we  in  4  byte write mask (0001 SB, 0011 SH, 1111 SW, 0000 load)
- d_req_wdata  in  32  store data
- d_resp_valid  out  1  one-cycle pulse, load data valid or store acknowledged
- d_resp_data  out  32  load data (don't-care for stores)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  memory address
- mem_req_we  out  4  memory byte write mask
- mem_req_wdata  out  32  memory write data
- mem_resp_valid  in  1  memory response or acknowledgement, one per accepted request
- mem_resp_data  in  32  memory read data
- busy  out  1  transaction in flight (state != IDLE)
- owner_d  out  1  in-flight transaction belongs to D

## Operation
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE → WAIT on mem_req_ready. If mem_resp_valid is also high in that cycle, go to IDLE instead.
  - WAIT → IDLE on mem_resp_valid.
- Grant (IDLE only, combinational from the valids):
  - D wins if d_req_valid and (!i_req_valid or starve_cnt < STARVE_LIMIT).
  - Otherwise I wins if i_req_valid.
  - Only the winner's req_ready goes high. Both readys are 0 outside IDLE.
- On accept, latch the address, mask, wdata and owner. For an I grant, mask = 0000 and wdata = 0.
- mem_req_* is driven from the latched registers only. It is held stable while mem_req_valid=1 and mem_req_ready=0.
- Response routing: in the completing cycle, the owner's resp_valid = mem_resp_valid, and its resp_data = mem_resp_data (combinational pass-through). The other side's resp_valid stays 0.
- mem_resp_valid is ignored in IDLE. No resp pulse is generated.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on a D grant while i_req_valid=1.
  - Clears on an I grant.
  - Otherwise holds.
- Requesters must hold valid and their fields stable until ready. Dropping valid before ready is allowed and simply withdraws the request.

## Timing
- Reset state: IDLE, starve_cnt=0, all latched fields 0. Every output is 0: readys, resp_valids, resp_datas, mem_req_*, busy, owner_d.
- Accept in cycle T. mem_req_valid is high from T+1.
- With mem_req_ready at T+1:
  - The earliest response is T+1 (same-cycle ack), giving resp_valid at T+1 and IDLE at T+2.
  - Otherwise WAIT from T+2, and resp_valid in the cycle mem_resp_valid arrives.
- Next accept is possible in the first IDLE cycle after completion. Minimum spacing between accepts is 2 cycles.
- Reset asserted mid-transaction: state is abandoned immediately and outputs go to reset values. A late mem_resp_valid arriving after release is ignored (IDLE).
- Simultaneous I and D valid in IDLE: exactly one ready. The loser is served at the next IDLE.

## Test plan
- Reset: assert reset_n=0 with requests active → all outputs 0. Release → busy=0, no ready until a valid is sampled.
- Single fetch: i_req_addr=0x00001000, mem_req_ready=1, memory returns 0x00000013 two cycles after issue:
  - i_req_ready at T.
  - mem_req_addr=0x00001000 and mem_req_we=0000 at T+1.
  - i_resp_valid with data 0x00000013 at T+3.
  - d_resp_valid stays 0.
- Tie: I and D valid together, D is an SW to 0x2000 with wdata 0xDEADBEEF:
  - D is granted first; mem_req_we=1111, mem_req_wdata=0xDEADBEEF.
  - I is granted at the next IDLE; i_resp_valid follows.
- Starvation, STARVE_LIMIT=4: D and I held valid continuously, memory with a 1-cycle ack:
  - Grant sequence is D,D,D,D,I,D,D,D,D,I.
  - starve_cnt clears on each I grant.
- Back-pressure: hold mem_req_ready=0 for 3 cycles during an SB to 0x3001 with mask 0001:
  - mem_req_* stays constant and both readys stay 0.
  - The transaction completes after ready and the response.
- Reset during WAIT, then mem_resp_valid pulsed after release → no i_resp_valid or d_resp_valid, busy=0, and the next request is accepted normally.
